// File: rtl/marv32_alu_issue.sv
// marv32 execute-stage front end: decodes RV32I OP/OP-IMM into ALU operands and opcode,
// registers them for the external ALU, and returns the registered result toward writeback.
module marv32_alu_issue #(
    parameter int ILLEGAL_PASS = 1
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        instr_valid_in,
    output logic        instr_ready_out,
    input  logic [31:0] instr_in,
    input  logic [31:0] rs1_data_in,
    input  logic [31:0] rs2_data_in,
    output logic [31:0] alu_op_1_out,
    output logic [31:0] alu_op_2_out,
    output logic [3:0]  alu_opcode_out,
    input  logic [31:0] alu_result_in,
    output logic        wb_valid_out,
    input  logic        wb_ready_in,
    output logic [4:0]  wb_rd_out,
    output logic [31:0] wb_data_out,
    output logic        wb_illegal_out
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm;
    logic        w_dec_illegal;
    logic        w_dec_alt;
    logic [31:0] w_dec_op2;
    logic        w_free;
    logic        w_accept;
    logic        w_e_adv;
    logic        w_w_load;
    logic        w_unused;

    logic        r_e_valid;
    logic [31:0] r_e_op1;
    logic [31:0] r_e_op2;
    logic [3:0]  r_e_opcode;
    logic [4:0]  r_e_rd;
    logic        r_e_illegal;
    logic        r_w_valid;
    logic [31:0] r_w_data;
    logic [4:0]  r_w_rd;
    logic        r_w_illegal;

    assign w_opc    = instr_in[6:0];
    assign w_f3     = instr_in[14:12];
    assign w_f7     = instr_in[31:25];
    assign w_imm    = {{20{instr_in[31]}}, instr_in[31:20]};
    assign w_unused = ^instr_in[19:15];

    // Decode the major opcode / funct fields into legality, alt bit and operand 2 source.
    always_comb begin
        w_dec_illegal = 1'b0;
        w_dec_alt     = 1'b0;
        w_dec_op2     = w_imm;
        case (w_opc)
            OPC_OP_IMM: begin
                w_dec_op2 = w_imm;
                case (w_f3)
                    3'b001: begin
                        if (w_f7 != F7_BASE) w_dec_illegal = 1'b1;
                        else                 w_dec_alt     = 1'b0;
                    end
                    3'b101: begin
                        if (w_f7 == F7_BASE)     w_dec_alt     = 1'b0;
                        else if (w_f7 == F7_ALT) w_dec_alt     = 1'b1;
                        else                     w_dec_illegal = 1'b1;
                    end
                    // ADDI and the other immediates ignore instr[30] entirely.
                    default: w_dec_alt = 1'b0;
                endcase
            end
            OPC_OP: begin
                w_dec_op2 = rs2_data_in;
                if (w_f7 == F7_BASE) begin
                    w_dec_alt = 1'b0;
                end else if (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
                    w_dec_alt = 1'b1;
                end else begin
                    w_dec_illegal = 1'b1;
                end
            end
            default: w_dec_illegal = 1'b1;
        endcase
    end

    // ready depends combinationally on wb_ready_in so a draining W frees E in the same cycle.
    assign w_free          = !r_w_valid || wb_ready_in;
    assign instr_ready_out = !reset_in && (!r_e_valid || w_free);
    assign w_accept        = instr_valid_in && instr_ready_out;
    assign w_e_adv         = r_e_valid && w_free;
    assign w_w_load        = w_e_adv && ((ILLEGAL_PASS != 0) || !r_e_illegal);

    // E stage: capture decoded operands on accept, empty when advancing without refill.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_e_valid   <= 1'b0;
            r_e_op1     <= 32'd0;
            r_e_op2     <= 32'd0;
            r_e_opcode  <= 4'd0;
            r_e_rd      <= 5'd0;
            r_e_illegal <= 1'b0;
        end else if (w_accept) begin
            r_e_valid   <= 1'b1;
            r_e_op1     <= w_dec_illegal ? 32'd0 : rs1_data_in;
            r_e_op2     <= w_dec_illegal ? 32'd0 : w_dec_op2;
            r_e_opcode  <= w_dec_illegal ? 4'd0 : {w_dec_alt, w_f3};
            r_e_rd      <= instr_in[11:7];
            r_e_illegal <= w_dec_illegal;
        end else if (w_e_adv) begin
            r_e_valid   <= 1'b0;
        end else begin
            r_e_valid   <= r_e_valid;
        end
    end

    // W stage: load the ALU result from E, otherwise clear once the sink takes the beat.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_w_valid   <= 1'b0;
            r_w_data    <= 32'd0;
            r_w_rd      <= 5'd0;
            r_w_illegal <= 1'b0;
        end else if (w_w_load) begin
            r_w_valid   <= 1'b1;
            r_w_data    <= r_e_illegal ? 32'd0 : alu_result_in;
            r_w_rd      <= r_e_rd;
            r_w_illegal <= r_e_illegal;
        end else if (wb_ready_in) begin
            r_w_valid   <= 1'b0;
        end else begin
            r_w_valid   <= r_w_valid;
        end
    end

    assign alu_op_1_out   = r_e_op1;
    assign alu_op_2_out   = r_e_op2;
    assign alu_opcode_out = r_e_opcode;
    assign wb_valid_out   = r_w_valid;
    assign wb_data_out    = r_w_data;
    assign wb_rd_out      = r_w_rd;
    assign wb_illegal_out = r_w_illegal;

endmodule

// File: tb/tb_marv32_alu_issue.sv
// Directed bench for marv32_alu_issue: one instance forwards illegal beats, one drops them;
// a small ALU model closes the loop on alu_*_out -> alu_result_in.
module tb_marv32_alu_issue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_in;
    logic        instr_valid_in;
    logic        wb_ready_in;
    logic [31:0] instr_in;
    logic [31:0] rs1_data_in;
    logic [31:0] rs2_data_in;

    logic        ready1, wbv1, ill1;
    logic [31:0] op1_1, op2_1, res1, data1;
    logic [3:0]  opc1;
    logic [4:0]  rd1;
    logic        ready0, wbv0, ill0;
    logic [31:0] op1_0, op2_0, res0, data0;
    logic [3:0]  opc0;
    logic [4:0]  rd0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] alu_model(input logic [3:0] opc, input logic [31:0] a,
                                              input logic [31:0] b);
        case (opc)
            4'h0:    return a + b;
            4'h8:    return a - b;
            4'h1:    return a << b[4:0];
            4'h2:    return {31'd0, $signed(a) < $signed(b)};
            4'h3:    return {31'd0, a < b};
            4'h4:    return a ^ b;
            4'h5:    return a >> b[4:0];
            4'hD:    return $unsigned($signed(a) >>> b[4:0]);
            4'h6:    return a | b;
            4'h7:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    assign res1 = alu_model(opc1, op1_1, op2_1);
    assign res0 = alu_model(opc0, op1_0, op2_0);

    marv32_alu_issue #(.ILLEGAL_PASS(1)) dut_pass (
        .clk_in(clk), .reset_in(reset_in), .instr_valid_in(instr_valid_in),
        .instr_ready_out(ready1), .instr_in(instr_in), .rs1_data_in(rs1_data_in),
        .rs2_data_in(rs2_data_in), .alu_op_1_out(op1_1), .alu_op_2_out(op2_1),
        .alu_opcode_out(opc1), .alu_result_in(res1), .wb_valid_out(wbv1),
        .wb_ready_in(wb_ready_in), .wb_rd_out(rd1), .wb_data_out(data1),
        .wb_illegal_out(ill1)
    );

    marv32_alu_issue #(.ILLEGAL_PASS(0)) dut_drop (
        .clk_in(clk), .reset_in(reset_in), .instr_valid_in(instr_valid_in),
        .instr_ready_out(ready0), .instr_in(instr_in), .rs1_data_in(rs1_data_in),
        .rs2_data_in(rs2_data_in), .alu_op_1_out(op1_0), .alu_op_2_out(op2_0),
        .alu_opcode_out(opc0), .alu_result_in(res0), .wb_valid_out(wbv0),
        .wb_ready_in(wb_ready_in), .wb_rd_out(rd0), .wb_data_out(data0),
        .wb_illegal_out(ill0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  opc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int acc;
        int got;

        vecs[0]  = '{32'h002081B3, 32'd5,        32'd7,        32'd5,        32'd7,        4'h0, 5'd3, 32'd12,       1'b0};
        vecs[1]  = '{32'h402081B3, 32'd5,        32'd7,        32'd5,        32'd7,        4'h8, 5'd3, 32'hFFFFFFFE, 1'b0};
        vecs[2]  = '{32'h4040D093, 32'h80000000, 32'h55,       32'h80000000, 32'h404,      4'hD, 5'd1, 32'hF8000000, 1'b0};
        vecs[3]  = '{32'hFFF00093, 32'h10,       32'h3,        32'h10,       32'hFFFFFFFF, 4'h0, 5'd1, 32'h0000000F, 1'b0};
        vecs[4]  = '{32'h40000093, 32'd5,        32'd9,        32'd5,        32'h400,      4'h0, 5'd1, 32'h405,      1'b0};
        vecs[5]  = '{32'h0040D093, 32'h80000000, 32'd0,        32'h80000000, 32'd4,        4'h5, 5'd1, 32'h08000000, 1'b0};
        vecs[6]  = '{32'h4020D0B3, 32'h80000000, 32'd4,        32'h80000000, 32'd4,        4'hD, 5'd1, 32'hF8000000, 1'b0};
        vecs[7]  = '{32'h0020C1B3, 32'hF0F0,     32'h0FF0,     32'hF0F0,     32'h0FF0,     4'h4, 5'd3, 32'hFF00,     1'b0};
        vecs[8]  = '{32'hFFF0A093, 32'hFFFFFFFE, 32'd0,        32'hFFFFFFFE, 32'hFFFFFFFF, 4'h2, 5'd1, 32'd1,        1'b0};
        vecs[9]  = '{32'h00000003, 32'd5,        32'd7,        32'd0,        32'd0,        4'h0, 5'd0, 32'd0,        1'b1};
        vecs[10] = '{32'h4020F0B3, 32'd5,        32'd7,        32'd0,        32'd0,        4'h0, 5'd1, 32'd0,        1'b1};
        vecs[11] = '{32'h40109093, 32'd5,        32'd7,        32'd0,        32'd0,        4'h0, 5'd1, 32'd0,        1'b1};

        reset_in       = 1'b1;
        instr_valid_in = 1'b0;
        wb_ready_in    = 1'b1;
        instr_in       = 32'd0;
        rs1_data_in    = 32'd0;
        rs2_data_in    = 32'd0;
        tick();
        tick();
        check("ready_in_reset", {31'd0, ready1}, 32'd0);
        reset_in = 1'b0;
        tick();
        check("reset_wb_valid", {31'd0, wbv1}, 32'd0);
        check("reset_wb_data", data1, 32'd0);
        check("reset_alu_op1", op1_1, 32'd0);
        check("reset_ready", {31'd0, ready1}, 32'd1);

        // Single beats: accept in N, ALU drive in N+1, writeback in N+2.
        for (int i = 0; i < 12; i++) begin
            instr_valid_in = 1'b1;
            instr_in       = vecs[i].instr;
            rs1_data_in    = vecs[i].rs1;
            rs2_data_in    = vecs[i].rs2;
            #1;
            check($sformatf("v%0d_ready", i), {31'd0, ready1}, 32'd1);
            tick();
            instr_valid_in = 1'b0;
            rs1_data_in    = 32'hDEADBEEF;
            rs2_data_in    = 32'hDEADBEEF;
            #1;
            check($sformatf("v%0d_opcode", i), {28'd0, opc1}, {28'd0, vecs[i].opc});
            check($sformatf("v%0d_op1", i), op1_1, vecs[i].op1);
            check($sformatf("v%0d_op2", i), op2_1, vecs[i].op2);
            check($sformatf("v%0d_wbv_early", i), {31'd0, wbv1}, 32'd0);
            tick();
            check($sformatf("v%0d_wbv", i), {31'd0, wbv1}, 32'd1);
            check($sformatf("v%0d_rd", i), {27'd0, rd1}, {27'd0, vecs[i].rd});
            check($sformatf("v%0d_data", i), data1, vecs[i].data);
            check($sformatf("v%0d_illegal", i), {31'd0, ill1}, {31'd0, vecs[i].ill});
            check($sformatf("v%0d_drop_wbv", i), {31'd0, wbv0}, {31'd0, !vecs[i].ill});
            if (!vecs[i].ill) begin
                check($sformatf("v%0d_drop_data", i), data0, vecs[i].data);
            end
        end

        // Backpressure: four ADDIs, sink stalled for the first four cycles.
        acc         = 0;
        got         = 0;
        rs1_data_in = 32'd0;
        for (int c = 0; c < 20; c++) begin
            tick();
            wb_ready_in    = (c >= 4);
            instr_valid_in = (acc < 4);
            instr_in       = {12'(acc + 1), 5'd0, 3'b000, 5'(acc + 1), 7'b0010011};
            #1;
            if (c == 2 || c == 3) begin
                check($sformatf("bp_ready_c%0d", c), {31'd0, ready1}, 32'd0);
                check($sformatf("bp_accepts_c%0d", c), 32'(acc), 32'd2);
                check($sformatf("bp_hold_valid_c%0d", c), {31'd0, wbv1}, 32'd1);
                check($sformatf("bp_hold_data_c%0d", c), data1, 32'd1);
                check($sformatf("bp_hold_rd_c%0d", c), {27'd0, rd1}, 32'd1);
            end
            if (wbv1 && wb_ready_in) begin
                if (got < 4) begin
                    check($sformatf("bp_order_%0d", got), data1, 32'(got + 1));
                    check($sformatf("bp_cycle_%0d", got), 32'(c), 32'(4 + got));
                end
                got++;
            end
            if (instr_valid_in && ready1) acc++;
        end
        instr_valid_in = 1'b0;
        check("bp_beats_out", 32'(got), 32'd4);

        // Reset with two beats in flight (an illegal one in W, an ADD in E).
        tick();
        wb_ready_in    = 1'b0;
        instr_valid_in = 1'b1;
        instr_in       = 32'h00000003;
        #1;
        tick();
        instr_in    = 32'h002081B3;
        rs1_data_in = 32'd3;
        rs2_data_in = 32'd4;
        #1;
        check("rst_second_accept", {31'd0, ready1}, 32'd1);
        tick();
        instr_valid_in = 1'b0;
        reset_in       = 1'b1;
        #1;
        check("rst_pre_illegal", {31'd0, ill1}, 32'd1);
        check("rst_ready_low", {31'd0, ready1}, 32'd0);
        tick();
        reset_in       = 1'b0;
        wb_ready_in    = 1'b1;
        instr_valid_in = 1'b1;
        instr_in       = 32'h002081B3;
        rs1_data_in    = 32'd9;
        rs2_data_in    = 32'd10;
        #1;
        check("rst_wb_valid", {31'd0, wbv1}, 32'd0);
        check("rst_wb_data", data1, 32'd0);
        check("rst_wb_rd", {27'd0, rd1}, 32'd0);
        check("rst_wb_illegal", {31'd0, ill1}, 32'd0);
        check("rst_alu_op1", op1_1, 32'd0);
        check("rst_alu_op2", op2_1, 32'd0);
        check("rst_alu_opcode", {28'd0, opc1}, 32'd0);
        check("rst_ready_after", {31'd0, ready1}, 32'd1);
        tick();
        instr_valid_in = 1'b0;
        #1;
        check("rst_no_stale_beat", {31'd0, wbv1}, 32'd0);
        check("rst_new_op1", op1_1, 32'd9);
        tick();
        check("rst_new_wbv", {31'd0, wbv1}, 32'd1);
        check("rst_new_data", data1, 32'd19);
        tick();
        check("rst_drained", {31'd0, wbv1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
